ringosc_meter: RTL and testbench

//  Reads the free-running GPIO ring-oscillator counter from the system-clock side.
//  - Controls the oscillator through its reset and halt lines.
//  - Gates it for a programmable window of clk cycles, halts it, and transfers the quasi-static count into the clk domain.
//  - Reports the edge count per window, from which the frequency is computed.
//  - Sits between the oscillator instance and the host/register interface.

---
 rtl/ringosc_pkg.sv | 23 ++
 rtl/ringosc_cnt_sync.sv | 46 ++++
 rtl/ringosc_meter.sv | 165 ++++++++++++++++
 tb/tb_ringosc_meter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ringosc_pkg.sv
// Shared types and helpers for the ring-oscillator meter.
`timescale 1ns/100ps
package ringosc_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    RUN    = 3'd2,
    HALT   = 3'd3,
    SAMPLE = 3'd4,
    DONE   = 3'd5
  } state_e;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/ringosc_cnt_sync.sv
// Per-bit 2-flop synchronizer for the halted oscillator count, plus a
// previous-word register so the caller can tell when the word has settled.
`timescale 1ns/100ps
module ringosc_cnt_sync
  import ringosc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [CNT_W-1:0] async_word_i,
  output logic [CNT_W-1:0] word_o,
  output logic             valid_o,
  output logic             stable_o
);

  logic [CNT_W-1:0] prev_q;
  logic [2:0]       fill_q;

  for (genvar gi = 0; gi < CNT_W; gi++) begin : g_bit
    (* async_reg = "true" *) logic meta_q;
    (* async_reg = "true" *) logic sync_q;

    always_ff @(posedge clk) begin
      if (en_i) begin
        meta_q <= async_word_i[gi];
        sync_q <= meta_q;
      end
    end

    assign word_o[gi] = sync_q;
  end

  always_ff @(posedge clk) begin
    if (en_i) prev_q <= word_o;
  end

  // Comparison is only trusted once both words were captured after enable.
  always_ff @(posedge clk) begin
    if (rst || !en_i) fill_q <= '0;
    else              fill_q <= {fill_q[1:0], 1'b1};
  end

  assign valid_o  = fill_q[2];
  assign stable_o = fill_q[2] && (word_o == prev_q);

endmodule

// File: rtl/ringosc_meter.sv
// Gated ring-oscillator edge counter readout: clear, run for a window, halt,
// settle, then capture a stable count. Optional min/max stats: RINGOSC_MINMAX_EN.
`timescale 1ns/100ps
module ringosc_meter
  import ringosc_pkg::*;
#(
  parameter int unsigned WIN_W      = 24,
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned SETTLE_CYC = 8,
  parameter int unsigned MAX_RETRY  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] window_len,
  output logic             osc_rst,
  output logic             osc_halt,
  input  logic [CNT_W-1:0] osc_counter,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result,
  output logic             err_unstable
`ifdef RINGOSC_MINMAX_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] res_min,
  output logic [CNT_W-1:0] res_max
`endif
);

  localparam int RETRY_W = clog2(MAX_RETRY + 1);

  state_e             state_q, state_d;
  logic [WIN_W-1:0]   tmr_q, tmr_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [CNT_W-1:0]   result_q, result_d;
  logic               err_q, err_d;
  logic               osc_rst_q, osc_halt_q, busy_q, done_q;

  logic [CNT_W-1:0]   sync_word;
  logic               sync_valid, sync_stable;

  ringosc_cnt_sync u_sync (
    .clk          (clk),
    .rst          (rst),
    .en_i         (state_q == SAMPLE),
    .async_word_i (osc_counter),
    .word_o       (sync_word),
    .valid_o      (sync_valid),
    .stable_o     (sync_stable)
  );

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    win_d    = win_q;
    retry_d  = retry_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          win_d   = (window_len == '0) ? WIN_W'(1) : window_len;
          tmr_d   = WIN_W'(RST_CYCLES - 1);
          state_d = CLR;
        end
      end
      CLR: begin
        if (tmr_q == '0) begin
          tmr_d   = win_q - WIN_W'(1);
          state_d = RUN;
        end else begin
          tmr_d = tmr_q - WIN_W'(1);
        end
      end
      RUN: begin
        if (tmr_q == '0) begin
          tmr_d   = WIN_W'(SETTLE_CYC - 1);
          state_d = HALT;
        end else begin
          tmr_d = tmr_q - WIN_W'(1);
        end
      end
      HALT: begin
        if (tmr_q == '0) begin
          retry_d = '0;
          state_d = SAMPLE;
        end else begin
          tmr_d = tmr_q - WIN_W'(1);
        end
      end
      SAMPLE: begin
        if (sync_valid) begin
          if (sync_stable) begin
            result_d = sync_word;
            err_d    = 1'b0;
            state_d  = DONE;
          end else if (retry_q == RETRY_W'(MAX_RETRY)) begin
            // Give up: report the last word seen, flagged as untrustworthy.
            result_d = sync_word;
            err_d    = 1'b1;
            state_d  = DONE;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      win_q      <= '0;
      retry_q    <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      osc_rst_q  <= 1'b1;
      osc_halt_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      win_q      <= win_d;
      retry_q    <= retry_d;
      result_q   <= result_d;
      err_q      <= err_d;
      osc_rst_q  <= (state_d == CLR);
      osc_halt_q <= (state_d != RUN);
      busy_q     <= (state_d != IDLE);
      done_q     <= (state_d == DONE);
    end
  end

  assign osc_rst      = osc_rst_q;
  assign osc_halt     = osc_halt_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign err_unstable = err_q;

`ifdef RINGOSC_MINMAX_EN
  logic [CNT_W-1:0] min_q, max_q;

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      min_q <= '1;
      max_q <= '0;
    end else if (state_q == DONE && !err_q) begin
      if (result_q < min_q) min_q <= result_q;
      if (result_q > max_q) max_q <= result_q;
    end
  end

  assign res_min = min_q;
  assign res_max = max_q;
`endif

endmodule

// File: tb/tb_ringosc_meter.sv
// Self-checking bench: behavioural ring oscillator (37 ns per edge, halt-gated,
// async clear) with window/latency/count expectations derived from timing.
`timescale 1ns/100ps
module tb_ringosc_meter;

  localparam int MAX_RETRY = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [23:0] window_len;
  logic        osc_rst, osc_halt, busy, done, err_unstable;
  logic [31:0] osc_cnt = '0;
  logic [31:0] result;
`ifdef RINGOSC_MINMAX_EN
  logic        stats_clr = 1'b0;
  logic [31:0] res_min, res_max;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ringosc_meter dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .window_len   (window_len),
    .osc_rst      (osc_rst),
    .osc_halt     (osc_halt),
    .osc_counter  (osc_cnt),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .err_unstable (err_unstable)
`ifdef RINGOSC_MINMAX_EN
    ,
    .stats_clr    (stats_clr),
    .res_min      (res_min),
    .res_max      (res_max)
`endif
  );

  // Oscillator model; "stuck" mode keeps counting fast even while halted.
  logic stuck = 1'b0;
  logic tick_slow = 1'b0;
  logic tick_fast = 1'b0;
  initial begin #0.3; forever #18.5 tick_slow = ~tick_slow; end
  initial begin #0.3; forever #3.5 tick_fast = ~tick_fast; end
  wire osc_tick = stuck ? tick_fast : tick_slow;

  always @(posedge osc_tick or posedge osc_rst) begin
    if (osc_rst)                osc_cnt <= '0;
    else if (stuck || !osc_halt) osc_cnt <= osc_cnt + 32'd1;
  end

  int rst_hi_n = 0, halt_lo_n = 0, done_n = 0;
  always @(negedge clk) begin
    if (osc_rst)   rst_hi_n++;
    if (!osc_halt) halt_lo_n++;
    if (done)      done_n++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // A window of w clk cycles (10 ns) holds 10w/37 oscillator edges, +-1.
  function automatic bit near(input logic [31:0] res, input int w);
    longint d;
    d = 37 * longint'(res) - 10 * longint'(w);
    return (d <= 37) && (d >= -37);
  endfunction

  task automatic measure(input int w, input bit inj, input bit stk);
    int lat, budget, weff, r0, h0, d0;
    weff   = (w == 0) ? 1 : w;
    budget = 17 + weff + MAX_RETRY + 20;
    stuck  = stk;
    @(negedge clk);
    r0 = rst_hi_n; h0 = halt_lo_n; d0 = done_n;
    window_len = w[23:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < budget) begin
      if (inj && lat == 10) begin
        start = 1'b1;
        window_len = 24'd50;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    // start coinciding with done must be dropped
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_done_start", busy, 0);
    check("latency", lat, 17 + weff + (stk ? MAX_RETRY : 0));
    check("osc_rst_cycles", rst_hi_n - r0, 4);
    check("halt_low_cycles", halt_lo_n - h0, weff);
    check("done_pulses", done_n - d0, 1);
    check("err_unstable", err_unstable, stk);
    if (!stk) check("result_near_model", near(result, weff), 1);
    $display("meas w=%0d stuck=%0b lat=%0d result=%0d err=%0b", w, stk, lat, result, err_unstable);
    stuck = 1'b0;
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    start = 1'b0;
    window_len = '0;
    repeat (3) @(negedge clk);
    check("rst_osc_rst", osc_rst, 1);
    check("rst_osc_halt", osc_halt, 1);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_err", err_unstable, 0);
    rst = 1'b0;
    d0 = done_n;
    repeat (10) @(negedge clk);
    check("idle_osc_halt", osc_halt, 1);
    check("idle_osc_rst", osc_rst, 0);
    check("idle_busy", busy, 0);
    check("idle_result", result, 0);
    check("idle_no_done", done_n - d0, 0);

    measure(1000, 1'b0, 1'b0);
    measure(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) measure(int'($urandom_range(1, 300)), 1'b0, 1'b0);
    measure(20, 1'b0, 1'b1);
    measure(200, 1'b1, 1'b0);
    measure(150, 1'b0, 1'b0);

    // reset while in SAMPLE aborts with no done pulse
    @(negedge clk);
    window_len = 24'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k < 114; k++) @(negedge clk);
    d0 = done_n;
    rst = 1'b1;
    @(negedge clk);
    check("abort_osc_halt", osc_halt, 1);
    check("abort_osc_rst", osc_rst, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_err", err_unstable, 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_done", done_n - d0, 0);
    check("abort_idle_busy", busy, 0);
    $display("meas abort w=100 result=%0d", result);

`ifdef RINGOSC_MINMAX_EN
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    check("stats_clr_min", res_min, 32'hFFFF_FFFF);
    check("stats_clr_max", res_max, 0);
    measure(1850, 1'b0, 1'b0);
    measure(1110, 1'b0, 1'b0);
    measure(2590, 1'b0, 1'b0);
    check("res_min_near_300", near(res_min, 1110), 1);
    check("res_max_near_700", near(res_max, 2590), 1);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    check("stats_clr2_min", res_min, 32'hFFFF_FFFF);
    check("stats_clr2_max", res_max, 0);
    $display("stats min=%0d max=%0d", res_min, res_max);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
